solver_result_fifo: RTL and testbench
=====================================

# solver_result_fifo

Captures every golden nonce reported by the block solver and buffers it for SPI readout. Sits directly downstream of the solver, between the solver's `state_out`/`nonce` outputs and the register file. Detects entry into the solver's FOUND state and pushes the nonce into a small first-word-fall-through FIFO. The register file drains the FIFO via a pop strobe, so a find is retained even if the solver resumes and the SPI host polls late.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16
- `NONCE_W`, 32, nonce width
- `FOUND_CODE`, 3'd4, solver state encoding meaning "nonce found"
- `clk`  in  1  design clock (slow clock domain shared with solver and register file)
- `reset`  in  1  asynchronous, active-high reset
- `state_in`  in  3  solver state
- `nonce`  in  NONCE_W  solver nonce; valid in the cycle `state_in == FOUND_CODE`
- `clear`  in  1  synchronous flush of FIFO and status
- `pop`  in  1  consume head entry; ignored when `head_valid` = 0
- `head_valid`  out  1  head entry present
- `head_nonce`  out  NONCE_W  oldest buffered nonce; 0 when empty
- `head_timestamp`  out  32  capture time of head entry (see Configuration)
- `count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `overflow`  out  1  sticky: a find was dropped because FIFO full
- `dropped`  out  8  saturating count of dropped finds

## Operation
- Registered `prev_state` tracks `state_in`; push event = `state_in == FOUND_CODE && prev_state != FOUND_CODE`. One event per FOUND entry, regardless of dwell time.
- On event: `nonce` sampled the same cycle and written at write pointer.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH; `count` is tracked separately.
- Full and push without pop: entry discarded, `overflow` set, `dropped` incremented, saturating at 255.
- Full with push and pop in the same cycle: pop frees the slot, push accepted, no overflow, `count` unchanged.
- Empty with push and pop in the same cycle: pop ignored, push accepted, `count` becomes 1.
- `pop` with `head_valid` = 0 has no effect; pointers never underflow.
- `clear` empties the FIFO (pointers, count = 0) and zeroes `overflow` and `dropped`. `clear` wins over a simultaneous push event, which is discarded and not counted. `prev_state` still updates.
- Outputs when empty: `head_nonce` = 0, `head_timestamp` = 0.

## Timing
- Reset (async assert; release synchronous to `clk`): `head_valid`=0, `head_nonce`=0, `head_timestamp`=0, `count`=0, `overflow`=0, `dropped`=0, pointers=0, `prev_state`=FOUND_CODE.
- Because `prev_state` resets to FOUND_CODE, a solver already in FOUND at reset release produces no entry.
- Push latency: event in cycle N → `head_valid`/`head_nonce`/`count` updated at edge ending N (visible cycle N+1).
- Pop latency: `pop` high in cycle N → next entry (or empty) visible in cycle N+1.
- `overflow` and `dropped` update at the same edge as the rejected push.
- Reset asserted mid-operation: all entries lost immediately, no partial state retained.

## Configuration
- `RESULT_TIMESTAMP_EN` defined:
  - a 32-bit free-running cycle counter (reset 0, wraps at 2^32) is built;
  - its value in the push-event cycle is stored alongside each nonce and presented on `head_timestamp` with the same latency as `head_nonce`.
- `RESULT_TIMESTAMP_EN` undefined:
  - counter and timestamp storage are not synthesized;
  - `head_timestamp` is tied to 0;
  - all other behaviour is identical.

## Test plan
- Single find: state 0→4 with nonce 0xDEADBEEF, held 5 cycles → exactly one entry; next cycle `head_valid`=1, `head_nonce`=0xDEADBEEF, `count`=1.
- Ordering and drain: finds 0x11, 0x22, 0x33, then 3 pops → heads 0x11, 0x22, 0x33 in order; final `count`=0, `head_nonce`=0.
- Overflow: 6 finds into DEPTH=4 with no pops → `count`=4, `overflow`=1, `dropped`=2, head still the first nonce.
- Full push+pop same cycle: FIFO full, find 0x55 together with pop → `count` stays 4, `overflow` stays 0, 0x55 at tail.
- Clear vs. push: `clear` in the same cycle as find 0x77 → `count`=0, `overflow`=0, `dropped`=0, 0x77 absent.
- Reset in FOUND: `reset` released while `state_in`=4 → no entry. With `RESULT_TIMESTAMP_EN`: a later find at cycle 100 after release gives `head_timestamp`=100.

Source files
------------

// File: rtl/solver_result_fifo.sv
// Captures solver golden nonces on FOUND entry into a FWFT FIFO drained by pop; push/pop visible next cycle.
// Full without pop drops the find and flags it. `RESULT_TIMESTAMP_EN adds a per-entry capture timestamp.
module solver_result_fifo #(
   parameter int         DEPTH      = 4,
   parameter int         NONCE_W    = 32,
   parameter logic [2:0] FOUND_CODE = 3'd4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2:0]                 state_in,
   input  logic [NONCE_W-1:0]         nonce,
   input  logic                       clear,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [NONCE_W-1:0]         head_nonce,
   output logic [31:0]                head_timestamp,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic [7:0]                 dropped
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [2:0]         prev_state_q, prev_state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [7:0]         dropped_q, dropped_d;
   logic [NONCE_W-1:0] mem_q [DEPTH];
   logic [NONCE_W-1:0] mem_d [DEPTH];

   logic push_ev, pop_ok, full, push_ok;

`ifdef RESULT_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_cnt_d;
   logic [31:0] ts_mem_q [DEPTH];
   logic [31:0] ts_mem_d [DEPTH];
`endif

   always_comb begin
      // One event per FOUND entry; prev_state resets to FOUND so a solver already there is ignored.
      push_ev = (state_in == FOUND_CODE) && (prev_state_q != FOUND_CODE);
      pop_ok  = pop && (count_q != '0);
      full    = (count_q == CNT_W'(DEPTH));
      push_ok = push_ev && (!full || pop_ok);

      prev_state_d = state_in;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      dropped_d    = dropped_q;
      mem_d        = mem_q;
`ifdef RESULT_TIMESTAMP_EN
      ts_cnt_d = ts_cnt_q + 32'd1;
      ts_mem_d = ts_mem_q;
`endif

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         dropped_d  = '0;
      end else begin
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok) begin
            mem_d[wr_ptr_q] = nonce;
`ifdef RESULT_TIMESTAMP_EN
            ts_mem_d[wr_ptr_q] = ts_cnt_q;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else if (push_ev) begin
            overflow_d = 1'b1;
            if (dropped_q != 8'hFF) begin
               dropped_d = dropped_q + 8'd1;
            end
         end
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_state_q <= FOUND_CODE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         dropped_q    <= '0;
         mem_q        <= '{default: '0};
      end else begin
         prev_state_q <= prev_state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         dropped_q    <= dropped_d;
         mem_q        <= mem_d;
      end
   end

`ifdef RESULT_TIMESTAMP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_cnt_q <= '0;
         ts_mem_q <= '{default: '0};
      end else begin
         ts_cnt_q <= ts_cnt_d;
         ts_mem_q <= ts_mem_d;
      end
   end

   assign head_timestamp = head_valid ? ts_mem_q[rd_ptr_q] : 32'd0;
`else
   assign head_timestamp = 32'd0;
`endif

   assign head_valid = (count_q != '0);
   assign head_nonce = head_valid ? mem_q[rd_ptr_q] : '0;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign dropped    = dropped_q;

endmodule

// File: tb/tb_solver_result_fifo.sv
// Directed vector-table bench for solver_result_fifo (DEPTH=4, NONCE_W=32).
module tb_solver_result_fifo;
   localparam int DEPTH   = 4;
   localparam int NONCE_W = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [2:0]         state_in;
   logic [NONCE_W-1:0] nonce;
   logic               clear;
   logic               pop;
   logic               head_valid;
   logic [NONCE_W-1:0] head_nonce;
   logic [31:0]        head_timestamp;
   logic [2:0]         count;
   logic               overflow;
   logic [7:0]         dropped;

   int checks   = 0;
   int failures = 0;

   solver_result_fifo #(.DEPTH(DEPTH), .NONCE_W(NONCE_W), .FOUND_CODE(3'd4)) dut (
      .clk(clk), .reset(reset), .state_in(state_in), .nonce(nonce), .clear(clear), .pop(pop),
      .head_valid(head_valid), .head_nonce(head_nonce), .head_timestamp(head_timestamp),
      .count(count), .overflow(overflow), .dropped(dropped)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  st;
      logic [31:0] n;
      logic        clr;
      logic        pp;
      logic        ev;
      logic [31:0] en;
      logic [2:0]  ec;
      logic        eo;
      logic [7:0]  ed;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] st, input logic [31:0] n, input logic clr, input logic pp,
                      input logic ev, input logic [31:0] en, input logic [2:0] ec,
                      input logic eo, input logic [7:0] ed);
      vec_t v;
      v.st = st; v.n = n; v.clr = clr; v.pp = pp;
      v.ev = ev; v.en = en; v.ec = ec; v.eo = eo; v.ed = ed;
      tbl.push_back(v);
   endtask

   // Drive inputs for one cycle, then sample 1 time unit after the edge.
   task automatic step(input logic [2:0] st, input logic [31:0] n, input logic clr, input logic pp);
      state_in = st; nonce = n; clear = clr; pop = pp;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic ev, input logic [31:0] en,
                          input logic [2:0] ec, input logic eo, input logic [7:0] ed);
      chk({tag, ".valid"}, 32'(head_valid), 32'(ev));
      chk({tag, ".nonce"}, head_nonce, en);
      chk({tag, ".count"}, 32'(count), 32'(ec));
      chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
      chk({tag, ".dropped"}, 32'(dropped), 32'(ed));
`ifndef RESULT_TIMESTAMP_EN
      chk({tag, ".ts"}, head_timestamp, 32'd0);
`endif
   endtask

   initial begin
      // Single find with 5-cycle dwell (nonce changes during dwell must not be captured)
      add(0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(4, 32'hDEADBEEF, 0, 0,  1, 32'hDEADBEEF, 1, 0, 0);
      for (int i = 0; i < 4; i++) add(4, 32'h12345678, 0, 0,  1, 32'hDEADBEEF, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'hDEADBEEF, 1, 0, 0);
      add(0, 0, 0, 1,  0, 0, 0, 0, 0);
      // Ordering and drain, then pop on empty
      add(4, 32'h11, 0, 0,  1, 32'h11, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'h11, 1, 0, 0);
      add(4, 32'h22, 0, 0,  1, 32'h11, 2, 0, 0);
      add(0, 0, 0, 0,  1, 32'h11, 2, 0, 0);
      add(4, 32'h33, 0, 0,  1, 32'h11, 3, 0, 0);
      add(0, 0, 0, 1,  1, 32'h22, 2, 0, 0);
      add(0, 0, 0, 1,  1, 32'h33, 1, 0, 0);
      add(0, 0, 0, 1,  0, 0, 0, 0, 0);
      add(0, 0, 0, 1,  0, 0, 0, 0, 0);
      // Overflow: 6 finds into 4 entries
      for (int i = 1; i <= 6; i++) begin
         add(4, 32'hA0 + 32'(i), 0, 0,  1, 32'hA1, 3'((i > 4) ? 4 : i), (i > 4), 8'((i > 4) ? i - 4 : 0));
         add(0, 0, 0, 0,  1, 32'hA1, 3'((i > 4) ? 4 : i), (i > 4), 8'((i > 4) ? i - 4 : 0));
      end
      // Clear wins over a simultaneous find
      add(4, 32'h77, 1, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0);
      // Fill, then full push+pop in the same cycle
      for (int i = 1; i <= 4; i++) begin
         add(4, 32'hB0 + 32'(i), 0, 0,  1, 32'hB1, 3'(i), 0, 0);
         add(0, 0, 0, 0,  1, 32'hB1, 3'(i), 0, 0);
      end
      add(4, 32'h55, 0, 1,  1, 32'hB2, 4, 0, 0);
      add(0, 0, 0, 1,  1, 32'hB3, 3, 0, 0);
      add(0, 0, 0, 1,  1, 32'hB4, 2, 0, 0);
      add(0, 0, 0, 1,  1, 32'h55, 1, 0, 0);
      add(0, 0, 0, 1,  0, 0, 0, 0, 0);
      // Empty push+pop: pop ignored
      add(4, 32'h66, 0, 1,  1, 32'h66, 1, 0, 0);
      add(0, 0, 0, 1,  0, 0, 0, 0, 0);

      state_in = 3'd4; nonce = 32'hCAFE0000; clear = 0; pop = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0);
      reset = 1'b0;
      // Solver held in FOUND across reset release: no entry
      step(4, 32'hCAFE0001, 0, 0);
      step(4, 32'hCAFE0002, 0, 0);
      chk_all("reset_in_found", 0, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         step(tbl[i].st, tbl[i].n, tbl[i].clr, tbl[i].pp);
         chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].en, tbl[i].ec, tbl[i].eo, tbl[i].ed);
      end

      // dropped saturates at 255
      step(0, 0, 1, 0);
      for (int i = 0; i < 4 + 260; i++) begin
         step(4, 32'hC0 + 32'(i), 0, 0);
         step(0, 0, 0, 0);
      end
      chk_all("saturate", 1, 32'hC0, 4, 1, 8'hFF);
      step(0, 0, 1, 0);
      chk_all("clear_after_sat", 0, 0, 0, 0, 0);

      // Async reset mid-operation drops entries before any clock edge
      step(4, 32'hD1, 0, 0);
      step(0, 0, 0, 0);
      chk_all("pre_async", 1, 32'hD1, 1, 0, 0);
      #2 reset = 1'b1;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Capture timestamp: find in the cycle where the counter reads 100
      for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
      step(4, 32'hE1, 0, 0);
      chk_all("ts_find", 1, 32'hE1, 1, 0, 0);
`ifdef RESULT_TIMESTAMP_EN
      chk("ts_value", head_timestamp, 32'd100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
